// File: rtl/csp_channel.sv
// -----------------------------------------------------------------------------
// csp_channel
//
// One-place clocked channel for 4-phase bundled-data links between CSP-style
// blocks. A sender pushes a WIDTH-bit token through the left handshake
// (l_req/l_ack). The token is held in a single register. It is offered to the
// receiver on the right handshake (r_req/r_ack) until the receiver completes
// its full 4-phase cycle.
//
// Optional feature macro: CHANNEL_STATS_EN
//   When defined, the channel adds the xfer_count port. This is a free-running
//   32-bit count of completed transfers. When undefined, the port and the
//   counter are absent, and all other behaviour is identical.
//
// Parameters
//   WIDTH       token width in bits (default 33, the PE packet width)
//
// Ports
//   clk         single clock, all state changes on the rising edge
//   rst         asynchronous, active-high reset
//   l_req       sender request; l_data is valid while high
//   l_data      sender data, bundled with l_req
//   l_ack       sender acknowledge (registered)
//   r_req       receiver request; r_data is valid while high (registered)
//   r_data      stored token (registered)
//   r_ack       receiver acknowledge
//   proto_err   sticky flag: receiver acknowledged with nothing offered
//   xfer_count  completed transfers (CHANNEL_STATS_EN only)
// -----------------------------------------------------------------------------
module csp_channel #(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             l_req,
  input  logic [WIDTH-1:0] l_data,
  output logic             l_ack,
  output logic             r_req,
  output logic [WIDTH-1:0] r_data,
  input  logic             r_ack,
  output logic             proto_err
`ifdef CHANNEL_STATS_EN
  ,
  output logic [31:0]      xfer_count
`endif
);

  // Sender-side handshake states.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } snd_state_t;

  // Receiver-side handshake states.
  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_REQ  = 2'd1,
    R_WAIT = 2'd2
  } rcv_state_t;

  snd_state_t       snd_state;
  snd_state_t       snd_next;
  rcv_state_t       rcv_state;
  rcv_state_t       rcv_next;

  logic             full;
  logic             full_next;
  logic [WIDTH-1:0] data_reg;
  logic [WIDTH-1:0] data_next;

  logic             l_ack_next;
  logic             r_req_next;
  logic             proto_err_next;

  // Single-cycle strobes: token written into / released from the register.
  logic             capture;
  logic             release_tok;

  // The stored token drives the receiver directly.
  // It changes only on capture, and capture requires the register to be
  // empty. So r_data cannot move while the receiver may be looking at it.
  assign r_data = data_reg;

  // Sender FSM: accept a token only into an empty register, then hold l_ack
  // until the sender returns l_req to zero.
  always_comb begin
    snd_next   = snd_state;
    l_ack_next = l_ack;
    capture    = 1'b0;
    case (snd_state)
      S_IDLE: begin
        if (l_req && !full) begin
          capture    = 1'b1;
          l_ack_next = 1'b1;
          snd_next   = S_ACK;
        end else begin
          // Covers back-pressure: request pending but register still occupied.
          l_ack_next = 1'b0;
          snd_next   = S_IDLE;
        end
      end
      S_ACK: begin
        if (!l_req) begin
          l_ack_next = 1'b0;
          snd_next   = S_IDLE;
        end else begin
          l_ack_next = 1'b1;
          snd_next   = S_ACK;
        end
      end
      default: begin
        l_ack_next = 1'b0;
        snd_next   = S_IDLE;
      end
    endcase
  end

  // Receiver FSM: offer the token, wait for r_ack high, then wait for r_ack low
  // before freeing the register.
  always_comb begin
    rcv_next       = rcv_state;
    r_req_next     = r_req;
    proto_err_next = proto_err;
    release_tok    = 1'b0;
    case (rcv_state)
      R_IDLE: begin
        // An acknowledge with no request outstanding is a receiver bug.
        if (r_ack) begin
          proto_err_next = 1'b1;
        end else begin
          proto_err_next = proto_err;
        end
        if (full) begin
          r_req_next = 1'b1;
          rcv_next   = R_REQ;
        end else begin
          r_req_next = 1'b0;
          rcv_next   = R_IDLE;
        end
      end
      R_REQ: begin
        if (r_ack) begin
          r_req_next = 1'b0;
          rcv_next   = R_WAIT;
        end else begin
          r_req_next = 1'b1;
          rcv_next   = R_REQ;
        end
      end
      R_WAIT: begin
        r_req_next = 1'b0;
        if (!r_ack) begin
          release_tok = 1'b1;
          rcv_next    = R_IDLE;
        end else begin
          rcv_next    = R_WAIT;
        end
      end
      default: begin
        r_req_next = 1'b0;
        rcv_next   = R_IDLE;
      end
    endcase
  end

  // Token register and occupancy.
  // Capture needs full=0 and release happens only while full=1, so the two
  // strobes are mutually exclusive within a cycle.
  always_comb begin
    full_next = full;
    data_next = data_reg;
    if (capture) begin
      full_next = 1'b1;
      data_next = l_data;
    end else if (release_tok) begin
      full_next = 1'b0;
      data_next = data_reg;
    end else begin
      full_next = full;
      data_next = data_reg;
    end
  end

  // State, handshake outputs and token storage.
  // Reset clears everything, discarding any in-flight token.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snd_state <= S_IDLE;
      rcv_state <= R_IDLE;
      l_ack     <= 1'b0;
      r_req     <= 1'b0;
      proto_err <= 1'b0;
      full      <= 1'b0;
      data_reg  <= '0;
    end else begin
      snd_state <= snd_next;
      rcv_state <= rcv_next;
      l_ack     <= l_ack_next;
      r_req     <= r_req_next;
      proto_err <= proto_err_next;
      full      <= full_next;
      data_reg  <= data_next;
    end
  end

`ifdef CHANNEL_STATS_EN
  logic [31:0] xfer_next;

  // Count one transfer per token release; wraps naturally at 2^32.
  always_comb begin
    if (release_tok) begin
      xfer_next = xfer_count + 32'd1;
    end else begin
      xfer_next = xfer_count;
    end
  end

  // Transfer counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_count <= 32'd0;
    end else begin
      xfer_count <= xfer_next;
    end
  end
`endif

endmodule

// File: tb/tb_csp_channel.sv
// -----------------------------------------------------------------------------
// tb_csp_channel
//
// Bench for csp_channel.
// - A cycle table covers a single token, back-pressure and data stability.
// - Hand-written sequences cover protocol errors and reset mid-handshake.
// - Randomised token streams use sender/receiver agents and a scoreboard
//   queue of expected tokens.
// -----------------------------------------------------------------------------
module tb_csp_channel;

  logic        clk = 1'b0;
  logic        rst;
  logic        l_req;
  logic [32:0] l_data;
  logic        l_ack;
  logic        r_req;
  logic [32:0] r_data;
  logic        r_ack;
  logic        proto_err;
`ifdef CHANNEL_STATS_EN
  logic [31:0] xfer_count;
`endif

  int tests    = 0;
  int failures = 0;

  always #5 clk = ~clk;

  csp_channel #(.WIDTH(33)) dut (
    .clk       (clk),
    .rst       (rst),
    .l_req     (l_req),
    .l_data    (l_data),
    .l_ack     (l_ack),
    .r_req     (r_req),
    .r_data    (r_data),
    .r_ack     (r_ack),
    .proto_err (proto_err)
`ifdef CHANNEL_STATS_EN
    ,
    .xfer_count(xfer_count)
`endif
  );

  typedef struct {
    logic        l_req;
    logic [32:0] l_data;
    logic        r_ack;
    logic        e_l_ack;
    logic        e_r_req;
    logic [32:0] e_r_data;
  } vec_t;

  vec_t tbl [15];

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk33(input string name, input logic [32:0] act, input logic [32:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [32:0] rnd33();
    logic [32:0] v;
    v[31:0] = $urandom;
    v[32]   = 1'($urandom_range(0, 1));
    return v;
  endfunction

  // Stream n random tokens through the channel.
  // The sender agent runs full 4-phase cycles with random idle gaps.
  // The receiver agent acknowledges after a random 0-7 cycle delay and
  // returns to zero after another random delay.
  task automatic run_stream(input int n);
    logic [32:0] toks[$];
    logic [32:0] seen;
    bit          stable;
    int tx = 0, rx = 0, s_ph = 0, s_dly = 0, r_ph = 0, r_dly = 0, cyc = 0;
    for (int i = 0; i < n; i++) toks.push_back(rnd33());
    while (rx < n && cyc < 4000) begin
      step();
      cyc++;
      // sender agent
      if (s_ph == 0) begin
        if (tx < n) begin
          if (s_dly == 0) begin
            l_req  = 1'b1;
            l_data = toks[tx];
            s_ph   = 1;
          end else begin
            s_dly--;
          end
        end
      end else if (s_ph == 1) begin
        if (l_ack) begin
          l_req  = 1'b0;
          l_data = rnd33();
          s_ph   = 2;
        end
      end else begin
        if (!l_ack) begin
          tx++;
          s_ph  = 0;
          s_dly = $urandom_range(0, 3);
        end
      end
      // receiver agent
      if (r_ph == 0 && r_req) begin
        seen   = r_data;
        stable = 1'b1;
        r_dly  = $urandom_range(0, 7);
        r_ph   = 1;
      end
      if (r_ph == 1) begin
        if (r_data !== seen) stable = 1'b0;
        if (r_dly == 0) begin
          chk33($sformatf("stream_data[%0d]", rx), r_data, toks[rx]);
          chk1($sformatf("stream_stable[%0d]", rx), stable, 1'b1);
          r_ack = 1'b1;
          r_ph  = 2;
        end else begin
          r_dly--;
        end
      end else if (r_ph == 2) begin
        if (!r_req) begin
          r_dly = $urandom_range(0, 7);
          r_ph  = 3;
        end
      end else if (r_ph == 3) begin
        if (r_dly == 0) begin
          r_ack = 1'b0;
          rx++;
          r_ph  = 0;
        end else begin
          r_dly--;
        end
      end
    end
    chk32("stream_done", 32'(rx), 32'(n));
    l_req = 1'b0;
    r_ack = 1'b0;
    repeat (3) step();
    chk1("stream_r_req_idle", r_req, 1'b0);
    chk1("stream_proto_err", proto_err, 1'b0);
  endtask

  initial begin
    // Cycle table: single token, back-pressure, data stability.
    tbl[0]  = '{1'b1, 33'h1_0000_00AB, 1'b0, 1'b1, 1'b0, 33'h1_0000_00AB};
    tbl[1]  = '{1'b0, 33'h0_0000_0000, 1'b0, 1'b0, 1'b1, 33'h1_0000_00AB};
    tbl[2]  = '{1'b0, 33'h0_0000_0000, 1'b1, 1'b0, 1'b0, 33'h1_0000_00AB};
    tbl[3]  = '{1'b0, 33'h0_0000_0000, 1'b0, 1'b0, 1'b0, 33'h1_0000_00AB};
    tbl[4]  = '{1'b1, 33'h0_DEAD_BEEF, 1'b0, 1'b1, 1'b0, 33'h0_DEAD_BEEF};
    tbl[5]  = '{1'b0, 33'h0_0000_0000, 1'b0, 1'b0, 1'b1, 33'h0_DEAD_BEEF};
    tbl[6]  = '{1'b1, 33'h0_0000_0005, 1'b0, 1'b0, 1'b1, 33'h0_DEAD_BEEF};
    tbl[7]  = '{1'b1, 33'h0_0000_0005, 1'b0, 1'b0, 1'b1, 33'h0_DEAD_BEEF};
    tbl[8]  = '{1'b1, 33'h0_0000_0005, 1'b1, 1'b0, 1'b0, 33'h0_DEAD_BEEF};
    tbl[9]  = '{1'b1, 33'h0_0000_0005, 1'b0, 1'b0, 1'b0, 33'h0_DEAD_BEEF};
    tbl[10] = '{1'b1, 33'h0_0000_0005, 1'b0, 1'b1, 1'b0, 33'h0_0000_0005};
    tbl[11] = '{1'b1, 33'h0_0000_0000, 1'b0, 1'b1, 1'b1, 33'h0_0000_0005};
    tbl[12] = '{1'b0, 33'h0_0000_0000, 1'b0, 1'b0, 1'b1, 33'h0_0000_0005};
    tbl[13] = '{1'b0, 33'h0_0000_0000, 1'b1, 1'b0, 1'b0, 33'h0_0000_0005};
    tbl[14] = '{1'b0, 33'h0_0000_0000, 1'b0, 1'b0, 1'b0, 33'h0_0000_0005};

    rst    = 1'b1;
    l_req  = 1'b0;
    l_data = 33'h0;
    r_ack  = 1'b0;
    repeat (2) step();
    chk1("reset_l_ack", l_ack, 1'b0);
    chk1("reset_r_req", r_req, 1'b0);
    chk33("reset_r_data", r_data, 33'h0);
    chk1("reset_proto_err", proto_err, 1'b0);
`ifdef CHANNEL_STATS_EN
    chk32("reset_xfer_count", xfer_count, 32'd0);
`endif
    rst = 1'b0;
    step();

    for (int i = 0; i < 15; i++) begin
      l_req  = tbl[i].l_req;
      l_data = tbl[i].l_data;
      r_ack  = tbl[i].r_ack;
      step();
      chk1($sformatf("tbl%0d_l_ack", i), l_ack, tbl[i].e_l_ack);
      chk1($sformatf("tbl%0d_r_req", i), r_req, tbl[i].e_r_req);
      chk33($sformatf("tbl%0d_r_data", i), r_data, tbl[i].e_r_data);
      chk1($sformatf("tbl%0d_proto_err", i), proto_err, 1'b0);
    end
`ifdef CHANNEL_STATS_EN
    chk32("tbl_xfer_count", xfer_count, 32'd3);
`endif

    // Protocol error: acknowledge with nothing offered, flag is sticky.
    r_ack = 1'b1;
    step();
    chk1("perr_set", proto_err, 1'b1);
    chk1("perr_no_r_req", r_req, 1'b0);
    r_ack = 1'b0;
    repeat (3) step();
    chk1("perr_sticky", proto_err, 1'b1);

    // Reset mid-handshake: asynchronous clear, token discarded.
    l_req  = 1'b1;
    l_data = 33'h0_1234_5678;
    step();
    chk1("rstmid_l_ack_pre", l_ack, 1'b1);
    step();
    chk1("rstmid_r_req_pre", r_req, 1'b1);
    #3 rst = 1'b1;
    #1;
    chk1("rstmid_l_ack", l_ack, 1'b0);
    chk1("rstmid_r_req", r_req, 1'b0);
    chk33("rstmid_r_data", r_data, 33'h0);
    chk1("rstmid_proto_err", proto_err, 1'b0);
    l_req = 1'b0;
    #2 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk1($sformatf("rstmid_after%0d_r_req", i), r_req, 1'b0);
      chk1($sformatf("rstmid_after%0d_l_ack", i), l_ack, 1'b0);
    end
`ifdef CHANNEL_STATS_EN
    chk32("rstmid_xfer_count", xfer_count, 32'd0);
`endif

    // Nine back-to-back tokens, then a longer random stream.
    run_stream(9);
`ifdef CHANNEL_STATS_EN
    chk32("stats_xfer_9", xfer_count, 32'd9);
`endif
    run_stream(30);
`ifdef CHANNEL_STATS_EN
    chk32("stats_xfer_39", xfer_count, 32'd39);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
